// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state and latched operation kind.
// Index widths depend on the port count and are derived inside each module.
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_READ  = 1'b0,
        ARB_WRITE = 1'b1
    } arb_op_t;

endpackage

// File: rtl/mem_arbiter_grant.sv
// Rotating-priority request select: first requester at or after the start index, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module arb_grant #(
    parameter int N_PORTS = 2,
    parameter int IDX_W   = 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               mode,
    output logic [IDX_W-1:0]   grant,
    output logic               grant_vld
);

    logic [IDX_W-1:0] start;
    int               idx;

    // Fixed priority is the rotating search anchored at index 0.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        start     = mode ? rr_ptr : '0;
        for (int i = 0; i < N_PORTS; i++) begin
            idx = int'(start) + i;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            if (!grant_vld && req[idx[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant     = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges N memory requesters onto one physical port (round-robin or fixed priority).
// Latency: strobe one cycle after request, req_resp one cycle after mem_resp; 3-cycle minimum turnaround.
// Backpressure: requests are held by the clients until req_resp; one transaction in flight at a time.
module mem_arbiter
    import arbiter_types::*;
#(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int RR_MODE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req_read,
    input  logic [N_PORTS-1:0]          req_write,
    input  logic [N_PORTS*ADDR_W-1:0]   req_address,
    input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
    output logic [N_PORTS-1:0]          req_resp,
    output logic [DATA_W-1:0]           req_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_resp,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int IDX_W = $clog2(N_PORTS);

    arb_state_t        state_q;
    arb_op_t           op_q;
    logic [IDX_W-1:0]  gnt_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic [N_PORTS-1:0] req_any;
    logic [IDX_W-1:0]   grant;
    logic               grant_vld;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_write;
    logic [IDX_W-1:0]   rr_ptr_nxt;

    assign req_any = req_read | req_write;

    arb_grant #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_grant (
        .req       (req_any),
        .rr_ptr    (rr_ptr_q),
        .mode      (RR_MODE != 0),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    // Constant-base slices keep the mux shallow and lint-clean for any port count.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant == IDX_W'(i)) begin
                sel_addr  = req_address[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_write = req_write[i];
            end
        end
    end

    assign rr_ptr_nxt = (grant == IDX_W'(N_PORTS - 1)) ? '0 : grant + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= ARB_READ;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        gnt_q   <= grant;
                        op_q    <= sel_write ? ARB_WRITE : ARB_READ;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        state_q <= ISSUE;
                        if (RR_MODE != 0) begin
                            rr_ptr_q <= rr_ptr_nxt;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_resp) begin
                        rdata_q <= mem_rdata;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Everything below is decoded from reset-cleared registers, so it drops with rst.
    always_comb begin
        req_resp = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            req_resp[i] = (state_q == RESP) && (gnt_q == IDX_W'(i));
        end
    end

    assign req_rdata   = rdata_q;
    assign mem_read    = (state_q == ISSUE) && (op_q == ARB_READ);
    assign mem_write   = (state_q == ISSUE) && (op_q == ARB_WRITE);
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 4-port round-robin instance driven by directed and random
// transactions against a cyclic-priority reference model, plus a 2-port fixed-priority instance.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 256;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0]    req_read, req_write, req_resp;
    logic [N*AW-1:0] req_address;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   req_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_address;
    logic            mem_read, mem_write, mem_resp, busy;

    logic [1:0]      fx_req_read, fx_req_write, fx_req_resp;
    logic [2*AW-1:0] fx_req_address;
    logic [2*DW-1:0] fx_req_wdata;
    logic [DW-1:0]   fx_req_rdata, fx_mem_wdata, fx_mem_rdata;
    logic [AW-1:0]   fx_mem_address;
    logic            fx_mem_read, fx_mem_write, fx_mem_resp, fx_busy;

    mem_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_resp(req_resp), .req_rdata(req_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.N_PORTS(2), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) dut_fx (
        .clk(clk), .rst(rst),
        .req_read(fx_req_read), .req_write(fx_req_write),
        .req_address(fx_req_address), .req_wdata(fx_req_wdata),
        .req_resp(fx_req_resp), .req_rdata(fx_req_rdata),
        .mem_read(fx_mem_read), .mem_write(fx_mem_write),
        .mem_address(fx_mem_address), .mem_wdata(fx_mem_wdata),
        .mem_resp(fx_mem_resp), .mem_rdata(fx_mem_rdata), .busy(fx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int ptr = 0;               // model's rotating-priority start index
    int resp_cnt [N];
    logic [DW-1:0] last_rd;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[DW-33:0], 32'($urandom)};
        return r;
    endfunction

    // Spec rule: first requester scanning cyclically from ptr.
    function automatic int model_grant(input logic [N-1:0] rq, input int p);
        int j;
        for (int i = 0; i < N; i++) begin
            j = (p + i) % N;
            if (rq[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic set_req(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_read[p]            = rd;
        req_write[p]           = wr;
        req_address[p*AW +: AW] = a;
        req_wdata[p*DW +: DW]   = d;
    endtask

    // Entered at a negedge with the DUT idle and requests driven; leaves at the next idle negedge.
    task automatic txn(input int delay, input logic [DW-1:0] rd, input bit perturb, input bit withdraw,
                       output int obs_g);
        logic [N-1:0]  rq, exp_resp;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
        bit            ewr;
        int            g;
        chk("idle_busy", busy, 0);
        rq    = req_read | req_write;
        g     = model_grant(rq, ptr);
        ewr   = req_write[g];
        eaddr = req_address[g*AW +: AW];
        ewd   = req_wdata[g*DW +: DW];
        ptr   = (g + 1) % N;
        for (int c = 1; c <= delay; c++) begin
            @(negedge clk);
            chk("issue_read", mem_read, !ewr);
            chk("issue_write", mem_write, ewr);
            chk("issue_addr", mem_address, eaddr);
            if (ewr) chk("issue_wdata", mem_wdata, ewd);
            chk("issue_busy", busy, 1);
            chk("issue_noresp", req_resp, 0);
            if (perturb) req_address[g*AW +: AW] = $urandom;
            if (withdraw && c == 1) begin
                req_read[g]  = 1'b0;
                req_write[g] = 1'b0;
            end
            if (c == delay) begin
                mem_resp  = 1'b1;
                mem_rdata = rd;
            end
        end
        @(negedge clk);
        mem_resp = 1'b0;
        exp_resp = '0;
        exp_resp[g] = 1'b1;
        chk("resp_onehot", req_resp, exp_resp);
        chk("resp_rdata", req_rdata, rd);
        chk("resp_strobes", {mem_read, mem_write}, 2'b00);
        chk("resp_busy", busy, 1);
        obs_g = -1;
        for (int i = 0; i < N; i++) if (req_resp[i]) obs_g = i;
        if (obs_g >= 0) resp_cnt[obs_g]++;
        last_rd      = rd;
        req_read[g]  = 1'b0;
        req_write[g] = 1'b0;
        @(negedge clk);
    endtask

    initial begin : main
        int g;
        int p1cnt;
        bit any;
        rst = 1'b1;
        req_read = '0; req_write = '0; req_address = '0; req_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        fx_req_read = '0; fx_req_write = '0; fx_req_address = '0; fx_req_wdata = '0;
        fx_mem_resp = 1'b0; fx_mem_rdata = '0;
        for (int i = 0; i < N; i++) resp_cnt[i] = 0;

        repeat (2) @(negedge clk);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_req_resp", req_resp, 0);
        chk("rst_req_rdata", req_rdata, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single read from port 1, mem_resp at cycle 4.
        set_req(1, 1'b1, 1'b0, 32'h0000_1000, '0);
        txn(4, {16'hDEAD, 224'h0, 16'hBEEF}, 1'b0, 1'b0, g);
        chk("single_port", g, 1);
        chk("single_busy_low", busy, 0);

        // Read+write on port 0: write wins; address changes during ISSUE are ignored.
        set_req(0, 1'b1, 1'b1, 32'h40, rand256());
        txn(3, rand256(), 1'b1, 1'b0, g);
        chk("rw_port", g, 0);

        // Spurious mem_resp while idle.
        mem_resp = 1'b1; mem_rdata = rand256();
        @(negedge clk);
        mem_resp = 1'b0;
        chk("spur_busy", busy, 0);
        chk("spur_resp", req_resp, 0);
        @(negedge clk);
        chk("spur_busy2", busy, 0);
        chk("spur_resp2", req_resp, 0);
        chk("spur_rdata", req_rdata, last_rd);

        // Reset in the middle of ISSUE.
        set_req(2, 1'b1, 1'b0, 32'h2000, '0);
        @(negedge clk);
        chk("pre_rst_read", mem_read, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_read", mem_read, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_resp", req_resp, 0);
        @(negedge clk);
        req_read = '0;
        rst = 1'b0;
        ptr = 0;
        @(negedge clk);
        chk("post_rst_resp", req_resp, 0);
        chk("post_rst_busy", busy, 0);

        // Round-robin fairness under full load, starting from the reset pointer.
        for (int i = 0; i < N; i++) resp_cnt[i] = 0;
        for (int t = 0; t < 8; t++) begin
            for (int p = 0; p < N; p++) set_req(p, 1'b1, 1'b0, 32'(32'h100 * (p + 1)), '0);
            txn(1, rand256(), 1'b0, 1'b0, g);
            chk("rr_order", g, t % N);
        end
        for (int p = 0; p < N; p++) chk("rr_count", resp_cnt[p], 2);
        req_read = '0;

        // Withdrawal mid-ISSUE still completes and pulses.
        set_req(3, 1'b1, 1'b0, 32'h3000, '0);
        txn(3, rand256(), 1'b0, 1'b1, g);
        chk("withdraw_port", g, 3);

        // Random traffic against the reference model.
        for (int t = 0; t < 30; t++) begin
            any = 1'b0;
            for (int p = 0; p < N; p++) begin
                if (!(req_read[p] | req_write[p]) && ($urandom_range(1, 0) == 1))
                    set_req(p, 1'($urandom), 1'($urandom), $urandom, rand256());
            end
            for (int p = 0; p < N; p++) any = any | req_read[p] | req_write[p];
            if (!any) set_req($urandom_range(N - 1, 0), 1'b1, 1'b0, $urandom, '0);
            txn($urandom_range(4, 1), rand256(), 1'($urandom), 1'($urandom), g);
        end
        req_read = '0; req_write = '0;

        // Fixed priority: port 0 always wins while both request.
        p1cnt = 0;
        fx_req_read = 2'b11;
        fx_req_address = {32'hB000, 32'hA000};
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("fx_addr", fx_mem_address, 32'hA000);
            chk("fx_read", fx_mem_read, 1);
            if (fx_req_resp[1]) p1cnt++;
            fx_mem_resp = 1'b1; fx_mem_rdata = rand256();
            @(negedge clk);
            fx_mem_resp = 1'b0;
            chk("fx_resp", fx_req_resp, 2'b01);
            if (fx_req_resp[1]) p1cnt++;
            @(negedge clk);
            if (fx_req_resp[1]) p1cnt++;
        end
        chk("fx_port1_never", p1cnt, 0);
        fx_req_read = '0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
